id_ext_ctrl: RTL and testbench
==============================

Name: id_ext_ctrl

Overview:
- Decode-stage controller that sequences the immediate extender.
- Accepts fetched instructions from IF over a valid/ready handshake and classifies each LoongArch32R opcode into the EXT_* immediate format.
- Registers the instruction, PC and selected ext_op into an ID/EX-facing output stage.
- A 2-entry skid buffer keeps IF streaming at full rate while EX back-pressures.

Parameters:
- SKID_EN, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single entry with in_ready = !out_valid | out_ready.
- PC_W, 32, width of PC field.

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- flush  in  1  synchronous pipeline flush from branch/exception unit.
- in_valid  in  1  IF beat valid.
- in_ready  out  1  block can accept a beat.
- in_inst  in  32  instruction word.
- in_pc  in  PC_W  instruction PC.
- out_valid  out  1  decoded beat valid.
- out_ready  in  1  EX accepts beat.
- out_inst  out  32  instruction word; bits [25:0] drive EXT din.
- out_pc  out  PC_W  PC.
- out_ext_op  out  3  EXT_* code from defines.vh, drives EXT ext_op.
- out_has_imm  out  1  1 when the opcode uses an extended immediate.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (clk, resetn).
- Reset values: out_valid=0, out_inst=0, out_pc=0, out_ext_op=3'd0 (default format), out_has_imm=0, skid empty, in_ready=1.
- Handshakes:
  - Transfer occurs on a cycle with valid&ready on that side.
  - out_* fields hold stable while out_valid=1 and out_ready=0.
- Latency: a beat accepted at edge N appears on out_* after edge N (1 cycle) when the output stage is empty or draining.
- SKID_EN=1:
  - in_ready is a register equal to "skid entry empty".
  - A beat accepted while output is stalled goes to the skid entry.
  - When the output drains, the skid moves to output the same edge, and in_ready returns to 1 the next cycle.
  - Simultaneous drain and accept with the skid empty: the new beat goes directly to output.
  - Order is strictly FIFO.
- Decode is combinational on the input beat and stored with it. Opcode fields, first match wins:
  - inst[31:15] in {0x00081 slli.w, 0x00089 srli.w, 0x00091 srai.w} -> EXT_2RI5U.
  - inst[31:22] in {0x008 slti, 0x009 sltui, 0x00A addi.w, 0x0A0-0x0A2 ld.b/h/w, 0x0A4-0x0A6 st.b/h/w, 0x0A8 ld.bu, 0x0A9 ld.hu} -> EXT_2RI12.
  - inst[31:22] in {0x00D andi, 0x00E ori, 0x00F xori} -> EXT_2RI12U.
  - inst[31:25] in {0x0A lu12i.w, 0x0E pcaddu12i} -> EXT_1RI20.
  - inst[31:26] in {0x13 jirl, 0x16-0x1B beq/bne/blt/bge/bltu/bgeu} -> EXT_2RI16.
  - inst[31:26] in {0x14 b, 0x15 bl} -> EXT_I26.
  - inst[31:24] in {0x20 ll.w, 0x21 sc.w} -> EXT_2RI14.
  - Otherwise ext_op=3'd0, has_imm=0.
  - has_imm=1 for every matched class.
- flush:
  - At the next edge, out_valid=0 and the skid is emptied; in_ready=1 the following cycle.
  - A beat handshaken in the flush cycle is discarded.
  - flush wins over every other event.
  - Data fields may keep stale values; only valid is cleared.
- resetn deassertion mid-stream: no beat is emitted until a new in_valid handshake.
- No combinational path from in_valid or in_inst to out_*.
- SKID_EN=0: the only combinational path is out_ready -> in_ready.

Test Plan:
- Reset: hold resetn=0 with random inputs -> out_valid=0, out_ext_op=0, in_ready=1; release resetn -> no output until a handshake.
- Decode sweep at out_ready=1:
  - 0x02801401 (addi.w) -> EXT_2RI12.
  - 0x03800000 (ori) -> EXT_2RI12U.
  - 0x00408000 (slli.w) -> EXT_2RI5U.
  - 0x14000000 (lu12i.w) -> EXT_1RI20.
  - 0x58000000 (beq) -> EXT_2RI16.
  - 0x50000000 (b) -> EXT_I26.
  - 0x20000000 (ll.w) -> EXT_2RI14.
  - 0xFFFFFFFF -> ext_op=0, has_imm=0.
  - Each result appears 1 cycle after acceptance.
- Back-pressure: stream PCs 0x1c000000, +4, +8 with out_ready=0 from cycle 1 -> first at output, second in skid, in_ready=0; raise out_ready -> three beats emitted in order, no loss or duplicate.
- Flush with full skid: assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed-cycle beat never appears.
- Random valid/ready with SKID_EN=0 and SKID_EN=1 against a scoreboard -> output sequence equals accepted input sequence, fields stable under stall.

Source files
------------

// File: rtl/id_ext_ctrl.sv
// Decode-stage controller: classifies LoongArch32R opcodes into EXT_* immediate formats and
// registers instruction, PC and format into an output stage, with an optional 2-entry skid buffer.
module id_ext_ctrl #(
  parameter bit          SKID_EN = 1'b1,
  parameter int unsigned PC_W    = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_inst,
  output logic [PC_W-1:0] out_pc,
  output logic [2:0]      out_ext_op,
  output logic            out_has_imm
);

  localparam logic [2:0] ExtNone   = 3'd0;
  localparam logic [2:0] Ext2Ri5U  = 3'd1;
  localparam logic [2:0] Ext2Ri12  = 3'd2;
  localparam logic [2:0] Ext2Ri12U = 3'd3;
  localparam logic [2:0] Ext1Ri20  = 3'd4;
  localparam logic [2:0] Ext2Ri16  = 3'd5;
  localparam logic [2:0] ExtI26    = 3'd6;
  localparam logic [2:0] Ext2Ri14  = 3'd7;

  logic            r_out_valid;
  logic [31:0]     r_out_inst;
  logic [PC_W-1:0] r_out_pc;
  logic [2:0]      r_out_ext_op;
  logic            r_out_has_imm;
  logic            r_skid_valid;
  logic [31:0]     r_skid_inst;
  logic [PC_W-1:0] r_skid_pc;
  logic [2:0]      r_skid_ext_op;
  logic            r_skid_has_imm;
  logic            r_in_ready;

  logic [2:0] w_ext_op;
  logic       w_has_imm;
  logic       w_out_take;
  logic       w_in_ready;
  logic       w_in_fire;

  // Priority decode: the first matching opcode class wins.
  always_comb begin
    w_ext_op = ExtNone;
    if (in_inst[31:15] inside {17'h00081, 17'h00089, 17'h00091}) begin
      w_ext_op = Ext2Ri5U;
    end else if (in_inst[31:22] inside {[10'h008:10'h00A], [10'h0A0:10'h0A2],
                                        [10'h0A4:10'h0A6], [10'h0A8:10'h0A9]}) begin
      w_ext_op = Ext2Ri12;
    end else if (in_inst[31:22] inside {[10'h00D:10'h00F]}) begin
      w_ext_op = Ext2Ri12U;
    end else if (in_inst[31:25] inside {7'h0A, 7'h0E}) begin
      w_ext_op = Ext1Ri20;
    end else if (in_inst[31:26] inside {6'h13, [6'h16:6'h1B]}) begin
      w_ext_op = Ext2Ri16;
    end else if (in_inst[31:26] inside {6'h14, 6'h15}) begin
      w_ext_op = ExtI26;
    end else if (in_inst[31:24] inside {8'h20, 8'h21}) begin
      w_ext_op = Ext2Ri14;
    end
    w_has_imm = (w_ext_op != ExtNone);
  end

  assign w_out_take = !r_out_valid || out_ready;
  assign w_in_ready = SKID_EN ? r_in_ready : w_out_take;
  assign w_in_fire  = in_valid && w_in_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_out_valid    <= 1'b0;
      r_out_inst     <= '0;
      r_out_pc       <= '0;
      r_out_ext_op   <= ExtNone;
      r_out_has_imm  <= 1'b0;
      r_skid_valid   <= 1'b0;
      r_skid_inst    <= '0;
      r_skid_pc      <= '0;
      r_skid_ext_op  <= ExtNone;
      r_skid_has_imm <= 1'b0;
      r_in_ready     <= 1'b1;
    end else if (flush) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
    end else if (w_out_take) begin
      r_in_ready <= 1'b1;
      if (r_skid_valid) begin
        r_out_valid   <= 1'b1;
        r_out_inst    <= r_skid_inst;
        r_out_pc      <= r_skid_pc;
        r_out_ext_op  <= r_skid_ext_op;
        r_out_has_imm <= r_skid_has_imm;
        r_skid_valid  <= 1'b0;
      end else if (w_in_fire) begin
        r_out_valid   <= 1'b1;
        r_out_inst    <= in_inst;
        r_out_pc      <= in_pc;
        r_out_ext_op  <= w_ext_op;
        r_out_has_imm <= w_has_imm;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else begin
      // Output stalled: a new beat can only park in the skid entry.
      r_in_ready <= !(r_skid_valid || w_in_fire);
      if (w_in_fire) begin
        r_skid_valid   <= 1'b1;
        r_skid_inst    <= in_inst;
        r_skid_pc      <= in_pc;
        r_skid_ext_op  <= w_ext_op;
        r_skid_has_imm <= w_has_imm;
      end
    end
  end

  assign in_ready    = w_in_ready;
  assign out_valid   = r_out_valid;
  assign out_inst    = r_out_inst;
  assign out_pc      = r_out_pc;
  assign out_ext_op  = r_out_ext_op;
  assign out_has_imm = r_out_has_imm;

endmodule

// File: tb/tb_id_ext_ctrl.sv
// Bench for id_ext_ctrl: index 1 is the skid-buffer instance, index 0 the single-entry one.
module tb_id_ext_ctrl;

  localparam logic [2:0] E_NONE = 3'd0, E_2RI5U = 3'd1, E_2RI12 = 3'd2, E_2RI12U = 3'd3;
  localparam logic [2:0] E_1RI20 = 3'd4, E_2RI16 = 3'd5, E_I26 = 3'd6, E_2RI14 = 3'd7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic        flush[2], in_valid[2], in_ready[2], out_valid[2], out_ready[2], out_has_imm[2];
  logic [31:0] in_inst[2], out_inst[2], in_pc[2], out_pc[2];
  logic [2:0]  out_ext_op[2];

  int n_checks = 0;
  int n_errors = 0;

  id_ext_ctrl #(.SKID_EN(1'b1), .PC_W(32)) u_dut_skid (
    .clk(clk), .resetn(resetn), .flush(flush[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .in_inst(in_inst[1]), .in_pc(in_pc[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_inst(out_inst[1]),
    .out_pc(out_pc[1]), .out_ext_op(out_ext_op[1]), .out_has_imm(out_has_imm[1])
  );

  id_ext_ctrl #(.SKID_EN(1'b0), .PC_W(32)) u_dut_flat (
    .clk(clk), .resetn(resetn), .flush(flush[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .in_inst(in_inst[0]), .in_pc(in_pc[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_inst(out_inst[0]),
    .out_pc(out_pc[0]), .out_ext_op(out_ext_op[0]), .out_has_imm(out_has_imm[0])
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Opcode classes as field ranges; earlier entries take priority.
  typedef struct {
    int unsigned lsb;
    int unsigned lo;
    int unsigned hi;
    logic [2:0]  code;
  } rule_t;
  rule_t rules[14];

  function automatic logic [3:0] ref_decode(input logic [31:0] inst);
    int unsigned f;
    for (int i = 0; i < 14; i++) begin
      f = inst >> rules[i].lsb;
      if (f >= rules[i].lo && f <= rules[i].hi) return {1'b1, rules[i].code};
    end
    return {1'b0, E_NONE};
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] v, mask;
    int unsigned i;
    if ($urandom_range(3, 0) == 0) return $urandom;
    i    = $urandom_range(13, 0);
    mask = (32'h1 << rules[i].lsb) - 32'h1;
    v    = $urandom_range(rules[i].hi, rules[i].lo);
    return (v << rules[i].lsb) | ($urandom & mask);
  endfunction

  // Scoreboard: beats currently held inside each DUT, oldest first.
  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } beat_t;
  beat_t       sb[2][64];
  int          wr[2] = '{0, 0};
  int          rd[2] = '{0, 0};
  logic        stall_q[2] = '{1'b0, 1'b0};
  logic [31:0] hold_inst[2], hold_pc[2];
  logic [3:0]  hold_dec[2];
  beat_t       b;
  int          occ;
  logic [3:0]  e;

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!resetn) begin
        rd[k]      = wr[k];
        stall_q[k] = 1'b0;
      end else begin
        occ = wr[k] - rd[k];
        if (stall_q[k]) begin
          chk("stall_valid", out_valid[k], 1'b1);
          chk("stall_inst", out_inst[k], hold_inst[k]);
          chk("stall_pc", out_pc[k], hold_pc[k]);
          chk("stall_dec", {out_has_imm[k], out_ext_op[k]}, hold_dec[k]);
        end
        if (k == 0) chk("in_ready_flat", in_ready[0], !out_valid[0] || out_ready[0]);
        else        chk("in_ready_skid", in_ready[1], occ < 2);
        if (occ == 0) chk("no_spurious_beat", out_valid[k], 1'b0);
        if (flush[k]) begin
          rd[k]      = wr[k];
          stall_q[k] = 1'b0;
        end else begin
          if (out_valid[k] && out_ready[k] && occ > 0) begin
            b = sb[k][rd[k] % 64];
            rd[k]++;
            e = ref_decode(b.inst);
            chk("sb_inst", out_inst[k], b.inst);
            chk("sb_pc", out_pc[k], b.pc);
            chk("sb_dec", {out_has_imm[k], out_ext_op[k]}, e);
          end
          if (in_valid[k] && in_ready[k]) begin
            sb[k][wr[k] % 64] = '{inst: in_inst[k], pc: in_pc[k]};
            wr[k]++;
          end
          stall_q[k]   = out_valid[k] && !out_ready[k];
          hold_inst[k] = out_inst[k];
          hold_pc[k]   = out_pc[k];
          hold_dec[k]  = {out_has_imm[k], out_ext_op[k]};
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] inst;
    logic [2:0]  op;
    logic        imm;
  } dec_vec_t;
  dec_vec_t    tbl[8];
  logic [31:0] got[$];
  logic        acc;

  initial begin
    rules[0]  = '{15, 'h81, 'h81, E_2RI5U};
    rules[1]  = '{15, 'h89, 'h89, E_2RI5U};
    rules[2]  = '{15, 'h91, 'h91, E_2RI5U};
    rules[3]  = '{22, 'h008, 'h00A, E_2RI12};
    rules[4]  = '{22, 'h0A0, 'h0A2, E_2RI12};
    rules[5]  = '{22, 'h0A4, 'h0A6, E_2RI12};
    rules[6]  = '{22, 'h0A8, 'h0A9, E_2RI12};
    rules[7]  = '{22, 'h00D, 'h00F, E_2RI12U};
    rules[8]  = '{25, 'h0A, 'h0A, E_1RI20};
    rules[9]  = '{25, 'h0E, 'h0E, E_1RI20};
    rules[10] = '{26, 'h13, 'h13, E_2RI16};
    rules[11] = '{26, 'h16, 'h1B, E_2RI16};
    rules[12] = '{26, 'h14, 'h15, E_I26};
    rules[13] = '{24, 'h20, 'h21, E_2RI14};
    tbl[0] = '{32'h02801401, E_2RI12, 1'b1};
    tbl[1] = '{32'h03800000, E_2RI12U, 1'b1};
    tbl[2] = '{32'h00408000, E_2RI5U, 1'b1};
    tbl[3] = '{32'h14000000, E_1RI20, 1'b1};
    tbl[4] = '{32'h58000000, E_2RI16, 1'b1};
    tbl[5] = '{32'h50000000, E_I26, 1'b1};
    tbl[6] = '{32'h20000000, E_2RI14, 1'b1};
    tbl[7] = '{32'hFFFFFFFF, E_NONE, 1'b0};

    resetn = 1'b0;
    for (int k = 0; k < 2; k++) begin
      flush[k] = 1'b0; in_valid[k] = 1'b0; out_ready[k] = 1'b1;
      in_inst[k] = '0; in_pc[k] = '0;
    end

    // Reset held with random activity on the inputs.
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 2; k++) begin
        in_valid[k] = 1'b1; in_inst[k] = $urandom; in_pc[k] = $urandom;
        out_ready[k] = 1'($urandom_range(1, 0));
      end
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        chk("rst_out_valid", out_valid[k], 1'b0);
        chk("rst_in_ready", in_ready[k], 1'b1);
        chk("rst_ext_op", out_ext_op[k], E_NONE);
        chk("rst_has_imm", out_has_imm[k], 1'b0);
        chk("rst_inst_pc", {out_inst[k], out_pc[k]}, 64'd0);
      end
      step();
    end
    for (int k = 0; k < 2; k++) begin
      in_valid[k] = 1'b0; out_ready[k] = 1'b1;
    end
    resetn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("post_rst_idle", out_valid[1], 1'b0);
      step();
    end

    // Decode sweep: one beat at a time, result expected one edge after acceptance.
    for (int i = 0; i < 8; i++) begin
      in_valid[1] = 1'b1; in_inst[1] = tbl[i].inst; in_pc[1] = 32'h1c000100 + 32'(i * 4);
      @(negedge clk);
      chk("dec_accept", in_ready[1], 1'b1);
      step();
      in_valid[1] = 1'b0;
      @(negedge clk);
      chk("dec_valid", out_valid[1], 1'b1);
      chk("dec_inst", out_inst[1], tbl[i].inst);
      chk("dec_ext_op", out_ext_op[1], tbl[i].op);
      chk("dec_has_imm", out_has_imm[1], tbl[i].imm);
      step();
    end

    // Back-pressure: A to output, B to skid, C waits; then drain in order.
    out_ready[1] = 1'b0; in_valid[1] = 1'b1; in_inst[1] = 32'h02801401; in_pc[1] = 32'h1c000000;
    step();
    in_pc[1] = 32'h1c000004;
    step();
    in_pc[1] = 32'h1c000008;
    @(negedge clk);
    chk("bp_out_valid", out_valid[1], 1'b1);
    chk("bp_out_pc", out_pc[1], 32'h1c000000);
    chk("bp_in_ready", in_ready[1], 1'b0);
    step();
    @(negedge clk);
    chk("bp_hold_pc", out_pc[1], 32'h1c000000);
    chk("bp_hold_ready", in_ready[1], 1'b0);
    step();
    out_ready[1] = 1'b1;
    acc = 1'b0;
    got.delete();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (out_valid[1] && out_ready[1]) got.push_back(out_pc[1]);
      if (in_valid[1] && in_ready[1]) acc = 1'b1;
      step();
      if (acc) in_valid[1] = 1'b0;
    end
    chk("bp_count", 64'(got.size()), 64'd3);
    if (got.size() == 3) begin
      chk("bp_order0", got[0], 32'h1c000000);
      chk("bp_order1", got[1], 32'h1c000004);
      chk("bp_order2", got[2], 32'h1c000008);
    end

    // Flush with a full skid, then flush while a beat is handshaken.
    out_ready[1] = 1'b0; in_valid[1] = 1'b1; in_pc[1] = 32'h1c000020;
    step();
    in_pc[1] = 32'h1c000024;
    step();
    in_pc[1] = 32'h1c000028;
    @(negedge clk);
    chk("fl_full_ready", in_ready[1], 1'b0);
    chk("fl_full_valid", out_valid[1], 1'b1);
    step();
    flush[1] = 1'b1;
    step();
    in_pc[1] = 32'h1c00002c;
    @(negedge clk);
    chk("fl_out_valid", out_valid[1], 1'b0);
    chk("fl_in_ready", in_ready[1], 1'b1);
    step();
    flush[1] = 1'b0; in_valid[1] = 1'b0; out_ready[1] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("fl_discard", out_valid[1], 1'b0);
      step();
    end

    // Random traffic on both instances, with varying back-pressure.
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 2; k++) begin
        in_valid[k]  = ($urandom_range(3, 0) != 0);
        in_inst[k]   = rand_inst();
        in_pc[k]     = $urandom;
        out_ready[k] = (c % 600 < 300) ? ($urandom_range(3, 0) != 0)
                                       : ($urandom_range(3, 0) == 0);
        flush[k]     = ($urandom_range(39, 0) == 0);
      end
      step();
    end
    for (int k = 0; k < 2; k++) begin
      in_valid[k] = 1'b0; flush[k] = 1'b0; out_ready[k] = 1'b1;
    end
    repeat (6) step();
    @(negedge clk);
    #1;
    for (int k = 0; k < 2; k++) chk("drain_empty", 64'(wr[k] - rd[k]), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
